// File: rtl/onehot_stream_decoder_pkg.sv
// Shared definitions for the one-hot stream decoder: FSM state encodings and default index width.
package onehot_stream_decoder_pkg;

    localparam int ONEHOT_N_DEFAULT = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_decodernbit.sv
// Combinational binary-to-one-hot decoder: d_out = 1 << d_in.
module onehot_decodernbit
    import onehot_stream_decoder_pkg::*;
#(
    parameter int N = ONEHOT_N_DEFAULT,
    parameter int M = 2**N
) (
    input  logic [N-1:0] d_in,
    output logic [M-1:0] d_out
);

    // Set exactly the bit addressed by d_in.
    always_comb begin
        d_out       = {M{1'b0}};
        d_out[d_in] = 1'b1;
    end

endmodule

// File: rtl/onehot_stream_decoder.sv
// Emits bursts of consecutive one-hot words from a (start index, count) request.
// Optional macro ONEHOT_STREAM_DIR_EN adds in_dir to step downward instead of upward.
module onehot_stream_decoder
    import onehot_stream_decoder_pkg::*;
#(
    parameter  int N = ONEHOT_N_DEFAULT,
    localparam int M = 2**N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_idx,
    input  logic [N-1:0] in_count,
`ifdef ONEHOT_STREAM_DIR_EN
    input  logic         in_dir,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_onehot,
    output logic         out_last,
    output logic         busy
);

    localparam logic [N-1:0] ZERO_N = {N{1'b0}};
    localparam logic [N-1:0] ONE_N  = N'(1);

    state_e         state_r;
    logic [N-1:0]   cur_r;
    logic [N-1:0]   rem_r;
    logic           out_valid_r;
    logic           out_last_r;
    logic           busy_r;
    logic           dir_s;
    logic [N-1:0]   cur_next_s;
    logic [M-1:0]   dec_s;

`ifdef ONEHOT_STREAM_DIR_EN
    logic           dir_r;

    // Direction is latched with each accepted request and cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_r <= 1'b0;
        end else if (in_valid && in_ready) begin
            dir_r <= in_dir;
        end else begin
            dir_r <= dir_r;
        end
    end

    assign dir_s = dir_r;
`else
    assign dir_s = 1'b0;
`endif

    // Index step; N-bit arithmetic wraps modulo M in both directions.
    always_comb begin
        cur_next_s = cur_r + ONE_N;
        if (dir_s) begin
            cur_next_s = cur_r - ONE_N;
        end else begin
            cur_next_s = cur_r + ONE_N;
        end
    end

    // A new request is taken when idle, or when the final word leaves this same cycle.
    assign in_ready = (state_r == ST_IDLE) ||
                      ((state_r == ST_EMIT) && out_last_r && out_ready);

    // Burst FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cur_r       <= ZERO_N;
            rem_r       <= ZERO_N;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_r     <= ST_EMIT;
                        cur_r       <= in_idx;
                        rem_r       <= in_count;
                        out_valid_r <= 1'b1;
                        out_last_r  <= (in_count == ZERO_N);
                        busy_r      <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (rem_r != ZERO_N) begin
                            cur_r      <= cur_next_s;
                            rem_r      <= rem_r - ONE_N;
                            out_last_r <= (rem_r == ONE_N);
                        end else if (in_valid) begin
                            // Chain the next burst with no idle bubble.
                            cur_r      <= in_idx;
                            rem_r      <= in_count;
                            out_last_r <= (in_count == ZERO_N);
                        end else begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    onehot_decodernbit #(
        .N (N),
        .M (M)
    ) u_dec (
        .d_in  (cur_r),
        .d_out (dec_s)
    );

    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;
    assign out_onehot = out_valid_r ? dec_s : {M{1'b0}};

endmodule

// File: tb/tb_onehot_stream_decoder.sv
// Scoreboard bench for onehot_stream_decoder (N=3); the direction test needs ONEHOT_STREAM_DIR_EN.
module tb_onehot_stream_decoder;

    typedef struct packed {
        logic [7:0] oh;
        logic       last;
        logic [2:0] idx;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic [2:0] in_count;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic       out_last;
    logic       busy;

    exp_t       sb_q[$];
    exp_t       e;
    int         checks;
    int         errors;

    onehot_stream_decoder #(.N(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_count   (in_count),
`ifdef ONEHOT_STREAM_DIR_EN
        .in_dir     (in_dir),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference one-hot-to-binary encoder used for round-trip checks.
    function automatic logic [3:0] enc(input logic [7:0] oh);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [2:0] idx, input logic last);
        exp_t x;
        x.oh   = 8'h01 << idx;
        x.last = last;
        x.idx  = idx;
        return x;
    endfunction

    task automatic request(input logic [2:0] idx, input logic [2:0] cnt, input logic dir);
        in_valid = 1'b1;
        in_idx   = idx;
        in_count = cnt;
        in_dir   = dir;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_onehot !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b onehot=%h busy=%b in_ready=%b required 0 00 0 1",
                     out_valid, out_onehot, busy, in_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        request(3'd5, 3'd0, 1'b0);
        sb_q.push_back(mk(3'd5, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== e.oh || out_last !== e.last) begin
            errors++;
            $display("FAIL single_word: valid=%b onehot=%h last=%b required 1 %h %b",
                     out_valid, out_onehot, out_last, e.oh, e.last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_onehot !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: valid=%b onehot=%h busy=%b required 0 00 0",
                     out_valid, out_onehot, busy);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        request(3'd6, 3'd3, 1'b0);
        sb_q.push_back(mk(3'd6, 1'b0));
        sb_q.push_back(mk(3'd7, 1'b0));
        sb_q.push_back(mk(3'd0, 1'b0));
        sb_q.push_back(mk(3'd1, 1'b1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = sb_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== e.oh || out_last !== e.last) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%b onehot=%h last=%b required 1 %h %b",
                         k, out_valid, out_onehot, out_last, e.oh, e.last);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        request(3'd2, 3'd2, 1'b0);
        sb_q.push_back(mk(3'd2, 1'b0));
        sb_q.push_back(mk(3'd3, 1'b0));
        sb_q.push_back(mk(3'd4, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (out_onehot !== e.oh || out_last !== e.last) begin
            errors++;
            $display("FAIL bp_first: onehot=%h last=%b required %h %b", out_onehot, out_last, e.oh, e.last);
        end
        @(negedge clk);
        out_ready = 1'b0;
        e = sb_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== e.oh || out_last !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b onehot=%h last=%b in_ready=%b required 1 %h 0 0",
                         k, out_valid, out_onehot, out_last, in_ready, e.oh);
            end
            if (k < 3) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== e.oh || out_last !== e.last) begin
            errors++;
            $display("FAIL bp_release: valid=%b onehot=%h last=%b required 1 %h %b",
                     out_valid, out_onehot, out_last, e.oh, e.last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        request(3'd7, 3'd0, 1'b0);
        sb_q.push_back(mk(3'd7, 1'b1));
        sb_q.push_back(mk(3'd0, 1'b1));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                request(3'd0, 3'd0, 1'b0);
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            e = sb_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== e.oh || out_last !== e.last) begin
                errors++;
                $display("FAIL b2b[%0d]: valid=%b onehot=%h last=%b required 1 %h %b",
                         k, out_valid, out_onehot, out_last, e.oh, e.last);
            end
            checks++;
            if (enc(out_onehot) !== {1'b0, e.idx}) begin
                errors++;
                $display("FAIL b2b_roundtrip[%0d]: got %0d required %0d", k, enc(out_onehot), e.idx);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        request(3'd0, 3'd5, 1'b0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_onehot !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b onehot=%h busy=%b in_ready=%b required 0 00 0 1",
                     out_valid, out_onehot, busy, in_ready);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_onehot !== 8'h00) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: valid=%b onehot=%h required 0 00",
                         k, out_valid, out_onehot);
            end
        end
    endtask

`ifdef ONEHOT_STREAM_DIR_EN
    task automatic test_dir();
        out_ready = 1'b1;
        request(3'd1, 3'd2, 1'b1);
        sb_q.push_back(mk(3'd1, 1'b0));
        sb_q.push_back(mk(3'd0, 1'b0));
        sb_q.push_back(mk(3'd7, 1'b1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = sb_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== e.oh || out_last !== e.last) begin
                errors++;
                $display("FAIL dir[%0d]: valid=%b onehot=%h last=%b required 1 %h %b",
                         k, out_valid, out_onehot, out_last, e.oh, e.last);
            end
        end
        @(negedge clk);
        in_dir = 1'b0;
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_idx    = 3'd0;
        in_count  = 3'd0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        @(negedge clk);
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef ONEHOT_STREAM_DIR_EN
        test_dir();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
